// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB arbiter bus: control, RS/LSB requester ports and broadcast outputs
interface cdb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8
);
  logic                  Sys_rdy;
  logic                  pre_judge;

  logic                  RSCDB_en;
  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index;
  logic [31:0]           RSCDB_value;
  logic [ADDR_WIDTH-1:0] RSCDB_next_pc;
  logic                  CDBRS_ready;

  logic                  LSBCDB_en;
  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index;
  logic [31:0]           LSBCDB_value;
  logic                  CDBLSB_ready;

  logic                  CDB_en;
  logic                  CDB_src;
  logic [RoB_WIDTH-1:0]  CDB_RoB_index;
  logic [31:0]           CDB_value;
  logic [ADDR_WIDTH-1:0] CDB_next_pc;

  modport master (
    output Sys_rdy, pre_judge,
    output RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
    input  CDBRS_ready,
    output LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    input  CDBLSB_ready,
    input  CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc
  );

  modport slave (
    input  Sys_rdy, pre_judge,
    input  RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
    output CDBRS_ready,
    input  LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    output CDBLSB_ready,
    output CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter between RS and LSB result FIFOs
// CDB_RR_EN defined: round-robin on contention; undefined: LSB has fixed priority.
module cdb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 2
) (
  input logic         Sys_clk,
  input logic         Sys_rst,
  cdb_arbiter_if.slave bus
);
  localparam int RS_W  = RoB_WIDTH + 32 + ADDR_WIDTH;
  localparam int LSB_W = RoB_WIDTH + 32;
  localparam logic [FIFO_WIDTH:0]   FULL  = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   C_ONE = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH-1:0] P_ONE = FIFO_WIDTH'(1);

  logic [RS_W-1:0]       rs_mem  [FIFO_DEPTH];
  logic [LSB_W-1:0]      lsb_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] rs_rd, rs_wr, lsb_rd, lsb_wr;
  logic [FIFO_WIDTH:0]   rs_cnt, lsb_cnt;
  logic                  last_grant;

  logic rs_ready, lsb_ready, rs_push, lsb_push, rs_pop, lsb_pop;
  logic grant_rs, grant_lsb, active;
  logic [RS_W-1:0]  rs_head;
  logic [LSB_W-1:0] lsb_head;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
  assign rs_ready         = (rs_cnt != FULL) && bus.pre_judge;
  assign lsb_ready        = (lsb_cnt != FULL) && bus.pre_judge;
  assign bus.CDBRS_ready  = rs_ready;
  assign bus.CDBLSB_ready = lsb_ready;

  assign active   = bus.Sys_rdy && bus.pre_judge;
  assign rs_push  = bus.RSCDB_en && rs_ready && bus.Sys_rdy;
  assign lsb_push = bus.LSBCDB_en && lsb_ready && bus.Sys_rdy;
  assign rs_head  = rs_mem[rs_rd];
  assign lsb_head = lsb_mem[lsb_rd];

  always_comb begin
    grant_rs  = 1'b0;
    grant_lsb = 1'b0;
    if ((rs_cnt != '0) && (lsb_cnt != '0)) begin
`ifdef CDB_RR_EN
      grant_lsb = !last_grant;
      grant_rs  = last_grant;
`else
      // last_grant is pinned to LSB here, which gives fixed LSB priority.
      grant_lsb = last_grant;
      grant_rs  = !last_grant;
`endif
    end else begin
      grant_rs  = (rs_cnt != '0);
      grant_lsb = (lsb_cnt != '0);
    end
  end

  assign rs_pop  = active && grant_rs;
  assign lsb_pop = active && grant_lsb;

  always_ff @(posedge Sys_clk) begin
    if (rs_push)
      rs_mem[rs_wr] <= {bus.RSCDB_RoB_index, bus.RSCDB_value, bus.RSCDB_next_pc};
    if (lsb_push)
      lsb_mem[lsb_wr] <= {bus.LSBCDB_RoB_index, bus.LSBCDB_value};
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      rs_rd             <= '0;
      rs_wr             <= '0;
      rs_cnt            <= '0;
      lsb_rd            <= '0;
      lsb_wr            <= '0;
      lsb_cnt           <= '0;
      last_grant        <= 1'b1;
      bus.CDB_en        <= 1'b0;
      bus.CDB_src       <= 1'b0;
      bus.CDB_RoB_index <= '0;
      bus.CDB_value     <= '0;
      bus.CDB_next_pc   <= '0;
    end else if (bus.Sys_rdy) begin
      if (!bus.pre_judge) begin
        rs_rd      <= '0;
        rs_wr      <= '0;
        rs_cnt     <= '0;
        lsb_rd     <= '0;
        lsb_wr     <= '0;
        lsb_cnt    <= '0;
        bus.CDB_en <= 1'b0;
      end else begin
        if (rs_push)  rs_wr  <= rs_wr + P_ONE;
        if (rs_pop)   rs_rd  <= rs_rd + P_ONE;
        if (lsb_push) lsb_wr <= lsb_wr + P_ONE;
        if (lsb_pop)  lsb_rd <= lsb_rd + P_ONE;
        case ({rs_push, rs_pop})
          2'b10:   rs_cnt <= rs_cnt + C_ONE;
          2'b01:   rs_cnt <= rs_cnt - C_ONE;
          default: rs_cnt <= rs_cnt;
        endcase
        case ({lsb_push, lsb_pop})
          2'b10:   lsb_cnt <= lsb_cnt + C_ONE;
          2'b01:   lsb_cnt <= lsb_cnt - C_ONE;
          default: lsb_cnt <= lsb_cnt;
        endcase
        bus.CDB_en <= rs_pop || lsb_pop;
        if (lsb_pop) begin
          bus.CDB_src       <= 1'b1;
          bus.CDB_RoB_index <= lsb_head[LSB_W-1 -: RoB_WIDTH];
          bus.CDB_value     <= lsb_head[31:0];
          bus.CDB_next_pc   <= '0;
        end else if (rs_pop) begin
          bus.CDB_src       <= 1'b0;
          bus.CDB_RoB_index <= rs_head[RS_W-1 -: RoB_WIDTH];
          bus.CDB_value     <= rs_head[ADDR_WIDTH +: 32];
          bus.CDB_next_pc   <= rs_head[ADDR_WIDTH-1:0];
        end
`ifdef CDB_RR_EN
        if (rs_pop || lsb_pop)
          last_grant <= lsb_pop;
`endif
      end
    end else begin
      bus.CDB_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed checks of cdb_arbiter against a queue model
module tb_cdb_arbiter;
  localparam int AW    = 32;
  localparam int RW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.ADDR_WIDTH(AW), .RoB_WIDTH(RW)) bus ();

  cdb_arbiter #(.ADDR_WIDTH(AW), .RoB_WIDTH(RW), .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(2)) dut (
    .Sys_clk (clk),
    .Sys_rst (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [RW-1:0] tag;
    logic [31:0]   value;
    logic [AW-1:0] npc;
  } ent_t;

  ent_t          rq[$];
  ent_t          lq[$];
  logic [RW-1:0] seen[$];
  int            errors = 0;
  int            checks = 0;
  logic          m_en, m_src, m_last;
  logic [RW-1:0] m_tag;
  logic [31:0]   m_val;
  logic [AW-1:0] m_npc;
  ent_t          z;

  function automatic ent_t mk(input logic [RW-1:0] t, input logic [31:0] v, input logic [AW-1:0] p);
    ent_t e;
    e.tag = t; e.value = v; e.npc = p;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete(); lq.delete(); seen.delete();
    m_en = 0; m_src = 0; m_tag = '0; m_val = '0; m_npc = '0; m_last = 1;
  endtask

  // One clock: drive at negedge, check readies, step model, check registered outputs after posedge.
  task automatic cycle(input logic rdy, input logic pj, input logic rs_en, input logic lsb_en,
                       input ent_t rd, input ent_t ld);
    bit rs_ok, lsb_ok;
    int g;
    ent_t e;
    @(negedge clk);
    bus.Sys_rdy = rdy; bus.pre_judge = pj;
    bus.RSCDB_en = rs_en; bus.RSCDB_RoB_index = rd.tag; bus.RSCDB_value = rd.value; bus.RSCDB_next_pc = rd.npc;
    bus.LSBCDB_en = lsb_en; bus.LSBCDB_RoB_index = ld.tag; bus.LSBCDB_value = ld.value;
    #1;
    chk("rs_ready", bus.CDBRS_ready, 32'((rq.size() != DEPTH) && pj));
    chk("lsb_ready", bus.CDBLSB_ready, 32'((lsb_q_size() != DEPTH) && pj));
    rs_ok  = rs_en && (rq.size() < DEPTH) && pj && rdy;
    lsb_ok = lsb_en && (lq.size() < DEPTH) && pj && rdy;
    if (!rdy) begin
      m_en = 0;
    end else if (!pj) begin
      rq.delete(); lq.delete(); m_en = 0;
    end else begin
      g = -1;
      if (rq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_RR_EN
        g = m_last ? 0 : 1;
`else
        g = 1;
`endif
      end else if (lq.size() > 0) g = 1;
      else if (rq.size() > 0) g = 0;
      m_en = (g >= 0);
      if (g == 1) begin
        e = lq.pop_front(); m_src = 1; m_tag = e.tag; m_val = e.value; m_npc = '0; m_last = 1;
      end else if (g == 0) begin
        e = rq.pop_front(); m_src = 0; m_tag = e.tag; m_val = e.value; m_npc = e.npc; m_last = 0;
      end
      if (rs_ok)  rq.push_back(rd);
      if (lsb_ok) lq.push_back(mk(ld.tag, ld.value, '0));
    end
    @(posedge clk); #1;
    chk("cdb_en", bus.CDB_en, 32'(m_en));
    chk("cdb_src", bus.CDB_src, 32'(m_src));
    chk("cdb_tag", bus.CDB_RoB_index, 32'(m_tag));
    chk("cdb_value", bus.CDB_value, m_val);
    chk("cdb_next_pc", bus.CDB_next_pc, m_npc);
    if (bus.CDB_en) seen.push_back(bus.CDB_RoB_index);
  endtask

  function automatic int lsb_q_size();
    return lq.size();
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, z, z);
  endtask

  task automatic do_reset();
    rst = 1;
    bus.Sys_rdy = 1; bus.pre_judge = 1; bus.RSCDB_en = 0; bus.LSBCDB_en = 0;
    bus.RSCDB_RoB_index = '0; bus.RSCDB_value = '0; bus.RSCDB_next_pc = '0;
    bus.LSBCDB_RoB_index = '0; bus.LSBCDB_value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_cdb_en", bus.CDB_en, 0);
    chk("rst_cdb_tag", bus.CDB_RoB_index, 0);
    chk("rst_rs_ready", bus.CDBRS_ready, 1);
    chk("rst_lsb_ready", bus.CDBLSB_ready, 1);
  endtask

  initial begin
    logic [RW-1:0] exp_seq[4];
    int   n;
    bit   full_lsb;
    z = mk('0, '0, '0);

    // Single RS push, broadcast one cycle later for exactly one cycle
    do_reset();
    cycle(1, 1, 1, 0, mk(8'h05, 32'h1234, 32'h100), z);
    chk("t1_not_yet", bus.CDB_en, 0);
    cycle(1, 1, 0, 0, z, z);
    chk("t1_en", bus.CDB_en, 1);
    chk("t1_src", bus.CDB_src, 0);
    chk("t1_tag", bus.CDB_RoB_index, 32'h05);
    chk("t1_value", bus.CDB_value, 32'h1234);
    chk("t1_npc", bus.CDB_next_pc, 32'h100);
    cycle(1, 1, 0, 0, z, z);
    chk("t1_one_cycle", bus.CDB_en, 0);

    // Four RS pushes back to back drain in order
    seen.delete();
    for (int i = 1; i <= 4; i++) cycle(1, 1, 1, 0, mk(RW'(i), 32'(i * 3), 32'(i * 16)), z);
    idle(2);
    chk("t2_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t2_order", seen[i], i + 1);

    // Fill one FIFO, freeze, pulse a push into the full FIFO: it must be dropped
    do_reset();
`ifdef CDB_RR_EN
    full_lsb = 1;
`else
    full_lsb = 0;
`endif
    n = 0;
    while ((full_lsb ? lq.size() : rq.size()) != DEPTH && n < 20) begin
      cycle(1, 1, 1, 1, mk(RW'($urandom_range(0, 127)), $urandom, $urandom),
                        mk(RW'($urandom_range(0, 127)), $urandom, '0));
      n++;
    end
    chk("t3_fill_bound", 32'(n < 20), 1);
    cycle(0, 1, !full_lsb, full_lsb, mk(8'hEE, 32'hDEAD, 32'h0), mk(8'hEE, 32'hDEAD, '0));
    chk("t3_ready_low", full_lsb ? bus.CDBLSB_ready : bus.CDBRS_ready, 0);
    chk("t3_model_full", full_lsb ? lq.size() : rq.size(), DEPTH);
    seen.delete();
    idle(12);
    n = 0;
    foreach (seen[i]) if (seen[i] == 8'hEE) n++;
    chk("t3_dropped", n, 0);

    // Ordering with two entries in each FIFO
    do_reset();
    cycle(1, 1, 1, 1, mk(8'd10, 32'h10, 32'h1000), mk(8'd20, 32'h20, '0));
    cycle(1, 1, 1, 1, mk(8'd11, 32'h11, 32'h1100), mk(8'd21, 32'h21, '0));
    idle(5);
`ifdef CDB_RR_EN
    exp_seq = '{8'd10, 8'd20, 8'd11, 8'd21};
`else
    exp_seq = '{8'd20, 8'd21, 8'd10, 8'd11};
`endif
    chk("t4_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t4_order", seen[i], exp_seq[i]);

    // Flush with a concurrent RS push
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 1, mk(RW'(40 + i), 32'(i), 32'(i)), mk(RW'(50 + i), 32'(i), '0));
    cycle(1, 0, 1, 0, mk(8'h77, 32'h77, 32'h77), z);
    chk("t5_en", bus.CDB_en, 0);
    bus.pre_judge = 1;
    #1;
    chk("t5_rs_ready", bus.CDBRS_ready, 1);
    chk("t5_lsb_ready", bus.CDBLSB_ready, 1);
    seen.delete();
    idle(5);
    chk("t5_no_bcast", seen.size(), 0);

    // Freeze for three cycles with one RS entry queued
    do_reset();
    cycle(1, 1, 1, 0, mk(8'h33, 32'h3333, 32'h300), z);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, z, z);
      chk("t6_frozen", bus.CDB_en, 0);
    end
    cycle(1, 1, 0, 0, z, z);
    chk("t6_en", bus.CDB_en, 1);
    chk("t6_tag", bus.CDB_RoB_index, 32'h33);

    // Asynchronous reset mid-cycle with entries queued
    cycle(1, 1, 1, 1, mk(8'h61, 32'h61, 32'h61), mk(8'h62, 32'h62, '0));
    cycle(1, 1, 1, 0, mk(8'h63, 32'h63, 32'h63), z);
    chk("t7_pre_en", bus.CDB_en, 1);
    #2;
    rst = 1;
    #1;
    chk("t7_en", bus.CDB_en, 0);
    chk("t7_tag", bus.CDB_RoB_index, 0);
    chk("t7_value", bus.CDB_value, 0);
    chk("t7_npc", bus.CDB_next_pc, 0);
    chk("t7_src", bus.CDB_src, 0);
    do_reset();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 16) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
            mk(RW'($urandom), $urandom, $urandom), mk(RW'($urandom), $urandom, '0));
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
